// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Front-end control stage for the stopwatch counter chain. Synchronises and
//   debounces the start/stop and lap/clear push-buttons, runs the
//   IDLE/RUN/PAUSE/LAP state machine and drives the counter chain controls.
//   Full scale on the final counter stage stops the watch automatically.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synchronised cycles to accept a level
//   DB_W             debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk         in   1  system clock, rising edge
//   resetn      in   1  synchronous active-low reset
//   btn_start   in   1  raw start/stop button, active-high, asynchronous
//   btn_lap     in   1  raw lap/clear button, active-high, asynchronous
//   tick_max    in   1  1-cycle pulse: counter chain at full scale
//   count_en    out  1  enable to every counter stage (RUN or LAP)
//   count_clrn  out  1  active-low 1-cycle clear strobe
//   lap_hold    out  1  display freeze while in LAP
//   state       out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DB_W            = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       tick_max,
  output logic       count_en,
  output logic       count_clrn,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int unsigned N_BTN     = 2;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_LAP   = 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_stable;
  logic [N_BTN-1:0] r_press;
  logic [DB_W-1:0]  r_db_cnt [N_BTN];

  logic [N_BTN-1:0] w_stable_nxt;
  logic [N_BTN-1:0] w_press_nxt;
  logic [DB_W-1:0]  w_db_cnt_nxt [N_BTN];

  assign w_raw = {btn_lap, btn_start};

  // Debounce next-state: accept a level after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    w_stable_nxt = r_stable;
    w_press_nxt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_db_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_stable_nxt[i] = r_sync2[i];
          // Pulse only on an accepted 0->1 level; releases are silent.
          w_press_nxt[i]  = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Synchroniser, stable level, debounce counter and press pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_press  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_press  <= w_press_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_db_cnt[i] <= w_db_cnt_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_clr_strobe;
  logic   w_start_p;
  logic   w_lap_p;
  logic   r_count_en;
  logic   r_lap_hold;
  logic   r_count_clrn;

  assign w_start_p = r_press[BTN_START];
  assign w_lap_p   = r_press[BTN_LAP];

  // Next state; priority tick_max > start > lap, so a lap press coincident
  // with a start press is discarded.
  always_comb begin
    w_state_nxt  = r_state;
    w_clr_strobe = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_p) begin
          w_state_nxt = ST_RUN;
        end else if (w_lap_p) begin
          w_state_nxt  = ST_IDLE;
          w_clr_strobe = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick_max || w_start_p) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_lap_p) begin
          w_state_nxt = ST_LAP;
        end
      end
      ST_LAP: begin
        if (tick_max || w_start_p) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_lap_p) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (w_start_p) begin
          w_state_nxt = ST_RUN;
        end else if (w_lap_p) begin
          w_state_nxt  = ST_IDLE;
          w_clr_strobe = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; outputs registered from the next state so they track
  // the state register exactly.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_count_en   <= 1'b0;
      r_lap_hold   <= 1'b0;
      r_count_clrn <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count_en   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
      r_lap_hold   <= (w_state_nxt == ST_LAP);
      r_count_clrn <= ~w_clr_strobe;
    end
  end

  assign count_en   = r_count_en;
  assign lap_hold   = r_lap_hold;
  assign count_clrn = r_count_clrn;
  assign state      = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4. Directed
//   scenarios check against fixed expectations; a randomized run checks
//   every cycle against a behavioural model of the button and FSM rules.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap   = 1'b0;
  logic       tick_max  = 1'b0;
  logic       count_en;
  logic       count_clrn;
  logic       lap_hold;
  logic [1:0] state;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .DB_W           (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .tick_max  (tick_max),
    .count_en  (count_en),
    .count_clrn(count_clrn),
    .lap_hold  (lap_hold),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int         m_state;
  bit         m_clrn;
  bit         m_stable [2];
  bit         m_press  [2];
  int         m_run    [2];
  logic [1:0] m_raw_q  [$];

  // One clock edge of the model, given the inputs sampled at that edge.
  task automatic model_edge(input bit s, input bit l, input bit t, input bit rn);
    int         nxt;
    bit         clr;
    logic [1:0] din;
    if (!rn) begin
      m_state = M_IDLE;
      m_clrn  = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_stable[b] = 1'b0;
        m_press[b]  = 1'b0;
        m_run[b]    = 0;
      end
      m_raw_q = {2'b00, 2'b00};
    end else begin
      nxt = m_state;
      clr = 1'b0;
      if (t && (m_state == M_RUN || m_state == M_LAP)) begin
        nxt = M_PAUSE;
      end else if (m_press[0]) begin
        nxt = (m_state == M_RUN || m_state == M_LAP) ? M_PAUSE : M_RUN;
      end else if (m_press[1]) begin
        if (m_state == M_RUN)      nxt = M_LAP;
        else if (m_state == M_LAP) nxt = M_RUN;
        else begin
          nxt = M_IDLE;
          clr = 1'b1;
        end
      end
      m_state = nxt;
      m_clrn  = !clr;
      // Raw level reaches the debouncer two edges after being sampled.
      din = m_raw_q.pop_front();
      m_raw_q.push_back({l, s});
      for (int b = 0; b < 2; b++) begin
        m_press[b] = 1'b0;
        if (din[b] != m_stable[b]) m_run[b]++;
        else                       m_run[b] = 0;
        if (m_run[b] == D) begin
          m_stable[b] = din[b];
          m_run[b]    = 0;
          m_press[b]  = din[b];
        end
      end
    end
  endtask

  // Drive inputs, advance one edge, settle, update model.
  task automatic cycle(input bit s, input bit l, input bit t, input bit rn);
    btn_start = s;
    btn_lap   = l;
    tick_max  = t;
    resetn    = rn;
    @(posedge clk);
    #1;
    model_edge(s, l, t, rn);
  endtask

  // Hold buttons 6 cycles, release; optional tick_max at cycle 6 (the edge
  // where the press acts). Reports clear-strobe cycles and first state change.
  task automatic press_btn(input bit s, input bit l, input bit tick6,
                           output int clr_lows, output int clr_edge, output int chg_edge);
    logic [1:0] st0;
    st0      = state;
    clr_lows = 0;
    clr_edge = -1;
    chg_edge = -1;
    for (int k = 0; k < 14; k++) begin
      cycle((k < 6) ? s : 1'b0, (k < 6) ? l : 1'b0, (k == 6) ? tick6 : 1'b0, 1'b1);
      if (count_clrn === 1'b0) begin
        clr_lows++;
        if (clr_edge < 0) clr_edge = k;
      end
      if (chg_edge < 0 && state !== st0) chg_edge = k;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (count_en !== 1'b0) $display("FAIL reset_count_en: got %b expected 0", count_en); else n_pass++;
    n_checks++; if (lap_hold !== 1'b0) $display("FAIL reset_lap_hold: got %b expected 0", lap_hold); else n_pass++;
    n_checks++; if (count_clrn !== 1'b0) $display("FAIL reset_clrn: got %b expected 0", count_clrn); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count_clrn !== 1'b1) $display("FAIL reset_release_clrn: got %b expected 1", count_clrn); else n_pass++;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_latency;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      if (k == 5) begin
        n_checks++; if (state !== 2'd0) $display("FAIL latency_edge5_state: got %0d expected 0", state); else n_pass++;
      end
      if (k == 6) begin
        n_checks++; if (state !== 2'd1) $display("FAIL latency_edge6_state: got %0d expected 1", state); else n_pass++;
        n_checks++; if (count_en !== 1'b1) $display("FAIL latency_edge6_en: got %b expected 1", count_en); else n_pass++;
      end
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd1) $display("FAIL release_no_change: got %0d expected 1", state); else n_pass++;
  endtask

  task automatic test_glitch;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd0) $display("FAIL glitch3_ignored: got %0d expected 0", state); else n_pass++;
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (state !== 2'd1) $display("FAIL glitch5_one_press: got %0d expected 1", state); else n_pass++;
  endtask

  task automatic test_lap;
    int lows, ce, ch;
    press_btn(1'b0, 1'b1, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd3) $display("FAIL lap_enter_state: got %0d expected 3", state); else n_pass++;
    n_checks++; if ({count_en, lap_hold} !== 2'b11) $display("FAIL lap_enter_outs: got %b expected 11", {count_en, lap_hold}); else n_pass++;
    n_checks++; if (ch !== 6) $display("FAIL lap_enter_edge: got %0d expected 6", ch); else n_pass++;
    press_btn(1'b0, 1'b1, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd1) $display("FAIL lap_exit_state: got %0d expected 1", state); else n_pass++;
    n_checks++; if (lap_hold !== 1'b0) $display("FAIL lap_exit_hold: got %b expected 0", lap_hold); else n_pass++;
  endtask

  task automatic test_pause_clear;
    int lows, ce, ch;
    press_btn(1'b1, 1'b0, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd2) $display("FAIL pause_state: got %0d expected 2", state); else n_pass++;
    n_checks++; if (count_en !== 1'b0) $display("FAIL pause_en: got %b expected 0", count_en); else n_pass++;
    press_btn(1'b0, 1'b1, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd0) $display("FAIL clear_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (lows !== 1) $display("FAIL clear_strobe_len: got %0d expected 1", lows); else n_pass++;
    n_checks++; if (ce !== ch) $display("FAIL clear_strobe_edge: got %0d expected %0d", ce, ch); else n_pass++;
    n_checks++; if (count_en !== 1'b0) $display("FAIL clear_en: got %b expected 0", count_en); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lows, ce, ch;
    for (int r = 0; r < 2; r++) begin
      press_btn(1'b0, 1'b1, 1'b0, lows, ce, ch);
      n_checks++; if (lows !== 1) $display("FAIL idle_lap_strobe%0d: got %0d expected 1", r, lows); else n_pass++;
      n_checks++; if (ce !== 6) $display("FAIL idle_lap_edge%0d: got %0d expected 6", r, ce); else n_pass++;
    end
    n_checks++; if (state !== 2'd0) $display("FAIL idle_lap_state: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_tick_max;
    int lows, ce, ch;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (state !== 2'd0) $display("FAIL tick_idle_ignored: got %0d expected 0", state); else n_pass++;
    press_btn(1'b1, 1'b0, 1'b0, lows, ce, ch);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (state !== 2'd2) $display("FAIL tick_run_state: got %0d expected 2", state); else n_pass++;
    n_checks++; if (count_en !== 1'b0) $display("FAIL tick_run_en: got %b expected 0", count_en); else n_pass++;
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (state !== 2'd2) $display("FAIL tick_pause_ignored: got %0d expected 2", state); else n_pass++;
    // LAP with tick_max coincident with a start press.
    press_btn(1'b1, 1'b0, 1'b0, lows, ce, ch);
    press_btn(1'b0, 1'b1, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd3) $display("FAIL tick_lap_setup: got %0d expected 3", state); else n_pass++;
    press_btn(1'b1, 1'b0, 1'b1, lows, ce, ch);
    n_checks++; if (state !== 2'd2) $display("FAIL tick_start_lap_state: got %0d expected 2", state); else n_pass++;
    n_checks++; if (lap_hold !== 1'b0) $display("FAIL tick_start_lap_hold: got %b expected 0", lap_hold); else n_pass++;
    n_checks++; if (ch !== 6) $display("FAIL tick_start_lap_edge: got %0d expected 6", ch); else n_pass++;
  endtask

  task automatic test_both_and_reset;
    int lows, ce, ch;
    press_btn(1'b1, 1'b1, 1'b0, lows, ce, ch);
    n_checks++; if (state !== 2'd1) $display("FAIL both_state: got %0d expected 1", state); else n_pass++;
    n_checks++; if (lows !== 0) $display("FAIL both_no_strobe: got %0d expected 0", lows); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({state, count_en, count_clrn} !== 4'b0000) $display("FAIL midreset_outs: got %b expected 0000", {state, count_en, count_clrn}); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count_clrn !== 1'b1) $display("FAIL midreset_clrn_back: got %b expected 1", count_clrn); else n_pass++;
    n_checks++; if (state !== 2'd0) $display("FAIL midreset_state: got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_random;
    int         hold_s, hold_l;
    bit         lv_s, lv_l, t, rn;
    logic [4:0] got, exp;
    hold_s = 0;
    hold_l = 0;
    lv_s   = 1'b0;
    lv_l   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (hold_s == 0) begin
        lv_s   = 1'($urandom_range(0, 1));
        hold_s = int'($urandom_range(1, 9));
      end
      if (hold_l == 0) begin
        lv_l   = 1'($urandom_range(0, 1));
        hold_l = int'($urandom_range(1, 9));
      end
      hold_s--;
      hold_l--;
      t  = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 499) != 0);
      cycle(lv_s, lv_l, t, rn);
      got = {state, count_en, lap_hold, count_clrn};
      exp = {2'(m_state), (m_state == M_RUN || m_state == M_LAP), (m_state == M_LAP), m_clrn};
      n_checks++;
      if (got !== exp) $display("FAIL random_cycle%0d: got %b expected %b", n, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_glitch();
    test_lap();
    test_pause_clear();
    test_back_to_back();
    test_tick_max();
    test_both_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
